// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: source banks, selectors, control and the
// registered operand pair offered to the ALU.
interface alu_operand_stage_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 3,
  parameter int SEL_W = 2
);
  logic [NSRC*WIDTH-1:0] src_a;
  logic [NSRC*WIDTH-1:0] src_b;
  logic [SEL_W-1:0]      sel_a;
  logic [SEL_W-1:0]      sel_b;
  logic                  start;
  logic                  flush;
  logic                  out_ready;
  logic [WIDTH-1:0]      op_a;
  logic [WIDTH-1:0]      op_b;
  logic                  out_valid;
  logic                  busy;
  logic                  sel_err;

  modport master (
    output src_a, src_b, sel_a, sel_b,
    output start, flush, out_ready,
    input  op_a, op_b, out_valid,
    input  busy, sel_err
  );

  modport slave (
    input  src_a, src_b, sel_a, sel_b,
    input  start, flush, out_ready,
    output op_a, op_b, out_valid,
    output busy, sel_err
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Multicycle ALU operand capture: A then B, then valid/ready hand-off.
// ALU_OPERAND_STAGE_ZERO_SRC_EN makes index NSRC a legal zero source.
module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 3,
  parameter int SEL_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  alu_operand_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE, CAP_A, CAP_B, VALID
  } state_e;

  state_e           state_q, state_d;
  logic             out_valid_q;
  logic [SEL_W-1:0] sel_a_q, sel_b_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic             sel_err_q;

  function automatic logic [WIDTH-1:0] pick(
    input logic [NSRC*WIDTH-1:0] srcs,
    input logic [SEL_W-1:0]      sel
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NSRC; i++)
      if (int'(sel) == i) r = srcs[i*WIDTH +: WIDTH];
    return r;
  endfunction

  function automatic logic illegal(
    input logic [SEL_W-1:0] sel
  );
`ifdef ALU_OPERAND_STAGE_ZERO_SRC_EN
    return int'(sel) > NSRC;
`else
    return int'(sel) >= NSRC;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == VALID);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = CAP_A;
      CAP_A: state_d = CAP_B;
      CAP_B: state_d = VALID;
      VALID: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.out_valid = out_valid_q;
    bus.op_a      = op_a_q;
    bus.op_b      = op_b_q;
    bus.sel_err   = sel_err_q;
  end

  // Flush abandons the request but keeps operands and error visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      sel_err_q <= 1'b0;
    end else if (!bus.flush) begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sel_a_q   <= bus.sel_a;
            sel_b_q   <= bus.sel_b;
            sel_err_q <= 1'b0;
          end
        end
        CAP_A: begin
          op_a_q <= pick(bus.src_a, sel_a_q);
          if (illegal(sel_a_q)) sel_err_q <= 1'b1;
        end
        CAP_B: begin
          op_b_q <= pick(bus.src_b, sel_b_q);
          if (illegal(sel_b_q)) sel_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
